// File: rtl/morse_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// morse_symbol_sequencer
//
// Classifies a keyed serial line into marks and gaps. Mark length decides
// dot versus dash; gap length decides whether the current character is
// closed and whether a word space follows. Finished characters and word
// spaces are handed downstream through a one-entry valid/ready buffer.
//
// Ports
//   clk        system clock, rising edge active
//   rst        asynchronous active-low reset
//   in         keyed line sample (1 = mark, 0 = space)
//   out_ready  downstream accepts the buffered token
//   ovf_clr    synchronous clear of the sticky overflow flag
//   out_valid  buffer holds a token
//   out_code   symbols LSB first, bit i = 1 means symbol i is a dash
//   out_len    number of symbols in the token (0 for a word space)
//   out_space  token is a word space
//   overflow   sticky error: symbol discarded or token dropped
//   state      current FSM state (00 idle, 01 mark, 10 gap)
// ---------------------------------------------------------------------------
module morse_symbol_sequencer #(
  parameter int DOT_MAX = 1,
  parameter int CB_GAP  = 3,
  parameter int WS_GAP  = 7,
  parameter int MAX_SYM = 6,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               out_ready,
  input  logic               ovf_clr,
  output logic               out_valid,
  output logic [MAX_SYM-1:0] out_code,
  output logic [2:0]         out_len,
  output logic               out_space,
  output logic               overflow,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MARK = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t             st;
  logic [CNT_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   gap_cnt;
  logic [2:0]         sym_len;
  logic [MAX_SYM-1:0] sym_reg;

  logic [CNT_W-1:0]   gap_inc;
  logic               is_dash;
  logic               emit_char;
  logic               emit_space;
  logic               emit;
  logic               pop;
  logic               load;
  logic               sym_ovf;
  logic               ovf_event;

  assign state = st;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    gap_inc    = (gap_cnt < CNT_W'(WS_GAP)) ? gap_cnt + 1'b1 : gap_cnt;
    is_dash    = run_cnt > CNT_W'(DOT_MAX);
    emit_char  = (st == GAP) && !in && (gap_inc == CNT_W'(CB_GAP));
    emit_space = (st == GAP) && !in && (gap_inc == CNT_W'(WS_GAP));
    emit       = emit_char || emit_space;
    pop        = out_valid && out_ready;
    // A token fits if the buffer is empty or drains on this same edge.
    load       = emit && (!out_valid || pop);
    sym_ovf    = (st == MARK) && !in && (sym_len == 3'(MAX_SYM));
    ovf_event  = sym_ovf || (emit && !load);
  end

  // NOTE: all state, including the symbol register, is cleared by the
  // asynchronous reset so an aborted character never leaks into a token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      run_cnt   <= '0;
      gap_cnt   <= '0;
      sym_len   <= '0;
      sym_reg   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_len   <= '0;
      out_space <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (st)
        IDLE: begin
          if (in) begin
            st      <= MARK;
            run_cnt <= CNT_W'(1);
            sym_len <= '0;
            sym_reg <= '0;
          end
        end
        MARK: begin
          if (in) begin
            if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
          end else begin
            if (sym_len != 3'(MAX_SYM)) begin
              sym_reg <= sym_reg | (MAX_SYM'(is_dash) << sym_len);
              sym_len <= sym_len + 1'b1;
            end
            gap_cnt <= CNT_W'(1);
            st      <= GAP;
          end
        end
        GAP: begin
          if (in) begin
            // A short gap continues the character; a long one starts a new one.
            if (gap_cnt >= CNT_W'(CB_GAP)) begin
              sym_len <= '0;
              sym_reg <= '0;
            end
            run_cnt <= CNT_W'(1);
            st      <= MARK;
          end else begin
            gap_cnt <= gap_inc;
            if (emit_space) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_code  <= emit_space ? '0 : sym_reg;
        out_len   <= emit_space ? 3'd0 : sym_len;
        out_space <= emit_space;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      if (ovf_event)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Controller that sequences the keyed serial line through mark/space classification. It measures mark lengths to build dot/dash symbols and uses gap lengths to detect character boundaries and inter-word spaces. It assembles each character into a packed code word and hands characters and word-space tokens downstream over a single-entry valid/ready output buffer. It sits between the raw `in` line and the character-decode/display logic.

## Interface
- `DOT_MAX`, 1: a mark of 1..DOT_MAX samples is a dot; a longer mark is a dash.
- `CB_GAP`, 3: consecutive zero samples that close a character (CB_GAP ≥ 2).
- `WS_GAP`, 7: consecutive zero samples that signal a word space (WS_GAP > CB_GAP).
- `MAX_SYM`, 6: maximum symbols per character, which is also the `out_code` width.
- `CNT_W`, 7: width of the run/gap counters.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in`  in  1  keyed line sample (1 = mark, 0 = space).
- `out_ready`  in  1  downstream accepts the token.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `out_valid`  out  1  output buffer holds a token.
- `out_code`  out  MAX_SYM  symbols, LSB first; bit i = 1 means symbol i is a dash. Unused bits are 0.
- `out_len`  out  3  symbol count, 0..MAX_SYM.
- `out_space`  out  1  token is a word space (`out_code`=0, `out_len`=0).
- `overflow`  out  1  sticky error flag.
- `state`  out  2  current FSM state.

## Operation
- States: IDLE=00, MARK=01, GAP=10. Encoding 11 is illegal and goes to IDLE on the next edge.
- IDLE:
  - in=1 → MARK, run_cnt=1, sym_len=0, sym_reg=0.
  - in=0 → stay.
- MARK:
  - in=1 → run_cnt+1, saturating at 2^CNT_W−1.
  - in=0 → append a symbol (dash if run_cnt > DOT_MAX) at bit position sym_len, sym_len+1, gap_cnt=1 → GAP.
  - If sym_len = MAX_SYM, the symbol is discarded, sym_len holds, and `overflow`=1.
- GAP, in=0:
  - gap_cnt+1, saturating at WS_GAP.
  - The edge on which gap_cnt becomes CB_GAP emits a character token {sym_reg, sym_len, space=0}.
  - The edge on which gap_cnt becomes WS_GAP emits a space token and the FSM goes to IDLE.
- GAP, in=1:
  - gap_cnt < CB_GAP → MARK, continuing the same character, run_cnt=1.
  - gap_cnt ≥ CB_GAP → MARK, starting a new character (sym_len=0, sym_reg=0, run_cnt=1).
- Output buffer (one entry):
  - A token is loaded when emitted and the buffer is empty or being popped in the same cycle (`out_valid` & `out_ready`).
  - Otherwise the new token is dropped, the buffer keeps its old contents, and `overflow`=1.
  - Pop on `out_valid` & `out_ready`: `out_valid`→0 unless loaded in the same cycle.
- `overflow` is sticky. It is cleared by `ovf_clr`=1, except that a new overflow event in the same cycle wins and sets it.
- Output fields are stable while `out_valid`=1 and not popped.

## Timing
- Reset (`rst`=0, asynchronous):
  - `state`=00; `out_valid`=0, `out_code`=0, `out_len`=0, `out_space`=0, `overflow`=0.
  - All counters and sym_reg=0.
- `in` is sampled on each rising edge. A symbol is appended on the edge sampling the first 0 after a mark.
- Character token latency: `out_valid` rises right after the edge sampling the CB_GAP-th consecutive zero.
- Space token: emitted on the edge sampling the WS_GAP-th zero; the FSM is in IDLE after that edge.
- Throughput: one token per cycle accepted when `out_ready` is held at 1.
- Reset asserted mid-MARK or mid-GAP aborts the character. No token is emitted.

## Test plan
- Reset: hold `rst`=0 with `in` toggling → `state`=00, `out_valid`=0, `overflow`=0 throughout. Release `rst` → still idle.
- Dot character: in=1 for 1 cycle, then 0×3, `out_ready`=1 → `out_valid` pulses 1 cycle after the 3rd zero sample, with `out_code`=000000, `out_len`=1, `out_space`=0.
- Dash-dot: in sequence 1,1,1,0,1,0,0,0 → `out_code`=000001, `out_len`=2. `state` passes through 01,10,01,10.
- Word space: in=1, then 0×7, `out_ready`=1 → character token at zero #3, then space token (`out_space`=1, `out_len`=0) at zero #7. Afterwards `state`=00.
- Backpressure: `out_ready`=0, in=1, then 0×7 → the character token is held, the space token is dropped, and `overflow`=1. Raise `out_ready` → the character pops. Then `ovf_clr`=1 → `overflow`=0.
- Symbol overflow and abort:
  - Seven dots separated by single zeros, then 0×3 → `out_len`=6, `overflow`=1.
  - Separately, assert `rst` during the 2nd mark → no token is emitted and `state`=00.
